dircc_node_mem_loader: RTL and testbench
========================================

# dircc_node_mem_loader

Packet-to-memory loader for the DiRCC node. Accepts inbound message packets from the node's network-side Avalon-ST sink and writes them, one packet per slot, into a ring of fixed-size slots inside the node's 32-bit single-port processing memory. It drives that memory's Avalon-MM slave write port, which is 14-bit word-addressed with byte enables. It signals the soft processor when packets are pending, and frees a slot when the processor pulses release.

## Interface
Parameters:
- BASE_ADDR, 8192: word address of slot 0 header; the ring must fit below 10240.
- SLOT_WORDS, 16: words per slot (power of two, ≥2); word 0 = header, words 1..SLOT_WORDS-1 = payload.
- NUM_SLOTS, 8: slots in ring (power of two, ≥2).

Ports:
- Clocking and reset (already decided): one clock; reset is asynchronous and active-low.
- clk  in  1  single clock.
- reset_n  in  1  asynchronous, active-low reset.
- in_data  in  32  sink payload word.
- in_valid  in  1  sink beat valid.
- in_startofpacket  in  1  first beat of packet.
- in_endofpacket  in  1  last beat of packet.
- in_ready  out  1  sink ready; a beat transfers when in_valid & in_ready.
- mem_address  out  14  word address to processing memory.
- mem_byteenable  out  4  always 4'hF during writes.
- mem_chipselect  out  1  asserted with mem_write.
- mem_write  out  1  one-cycle write strobe.
- mem_writedata  out  32  write data.
- mem_clken  out  1  constant 1.
- pkt_release  in  1  processor pulse: head slot consumed.
- pkt_pending  out  1  slot count ≠ 0.
- pkt_count  out  log2(NUM_SLOTS)+1  committed, unreleased slots.
- head_addr  out  14  BASE_ADDR + rd_slot*SLOT_WORDS (header of oldest packet).

## Operation
- State machine: IDLE, WRITE, DROP, COMMIT.
- IDLE: in_ready = !full (full ⇔ pkt_count == NUM_SLOTS).
  - Accepted beat with sop: write in_data at slot offset 1, set offset=2, stored=1. Go to COMMIT if eop is also set, else WRITE.
  - Accepted beat without sop: discarded; stay IDLE.
- WRITE: in_ready = 1.
  - Each accepted beat is written at the current offset; offset++ and stored++.
  - When offset reaches SLOT_WORDS after a write and eop is not set, set ovf and go to DROP.
  - Accepted eop beat: go to COMMIT.
  - Accepted sop beat: the partial packet is abandoned. The beat is written at offset 1; offset=2, stored=1, ovf=0.
- DROP: in_ready = 1; beats are consumed without writes. eop → COMMIT. sop restarts the packet as in WRITE.
- COMMIT (one cycle): in_ready = 0.
  - Header write: {ovf, 15'b0, stored[15:0]} at slot offset 0.
  - wr_slot advances modulo NUM_SLOTS; pkt_count++ (net of release); go to IDLE.
- Address arithmetic: mem_address = BASE_ADDR + wr_slot*SLOT_WORDS + offset, truncated to 14 bits.
- Release: pkt_release with pkt_count ≠ 0 advances rd_slot and decrements pkt_count. Release while pkt_count == 0 is ignored.
- Commit and release in the same cycle: pkt_count unchanged; both pointers advance.
- Reset (asynchronous, any state):
  - State=IDLE; all pointers, offset, stored, ovf and pkt_count = 0.
  - mem_write = mem_chipselect = 0; mem_address = 0; mem_writedata = 0.
  - pkt_pending = 0; head_addr = BASE_ADDR.
  - in_ready = 0 while reset_n is low; it asserts in the first cycle after deassertion.
  - A partial packet is lost; no header is written.

## Timing
- Memory outputs are registered. The write for a beat accepted in cycle N appears on mem_* in cycle N+1, for exactly one cycle.
- The header write appears in the cycle after COMMIT is entered, i.e. two cycles after the eop beat is accepted.
- pkt_count and pkt_pending update in that same cycle, so the header is in memory before pkt_pending rises.
- in_ready is registered-free combinational from state and full, with no in_valid dependence.
- Throughput: one beat per cycle within a packet; a one-cycle bubble per packet (COMMIT).
- head_addr and pkt_count update the cycle after pkt_release.

## Test plan
- Single 3-word packet (sop A0, A1, eop A2) after reset:
  - Writes appear at 8193/8194/8195 with A0/A1/A2, then header 0x00000003 at 8192.
  - pkt_count=1; head_addr=8192.
- 1-beat packet (sop&eop, 0xDEADBEEF): payload write at offset 1, then header 0x00000001; in_ready low for exactly one cycle.
- 20-word packet with SLOT_WORDS=16: 15 payload writes, 5 beats dropped with in_ready high, header 0x8000000F.
- Ring full and wrap:
  - 8 packets committed without release: in_ready=0 in IDLE.
  - One pkt_release reopens the sink; the 9th packet lands in slot 0 (header 8192), and head_addr=8208.
- Simultaneous events:
  - pkt_release in the COMMIT cycle leaves pkt_count unchanged.
  - pkt_release while pkt_count=0 leaves all state unchanged.
  - sop mid-packet restarts the write at offset 1.
- reset_n asserted mid-WRITE:
  - mem_write drops immediately (asynchronously); no header is written.
  - After release, a new packet writes slot 0 and pkt_count=1.

Source files
------------

// File: rtl/dircc_node_mem_loader.sv
// Packet-to-memory loader: writes each inbound Avalon-ST packet into one slot of a ring in processing memory.
// Latency: payload write on mem_* one cycle after the beat; header two cycles after eop, with pkt_count.
// Backpressure: in_ready drops when the ring is full (IDLE only) and during the one-cycle COMMIT bubble.
module dircc_node_mem_loader #(
  parameter int BASE_ADDR  = 8192,
  parameter int SLOT_WORDS = 16,
  parameter int NUM_SLOTS  = 8
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [31:0]                  in_data,
  input  logic                         in_valid,
  input  logic                         in_startofpacket,
  input  logic                         in_endofpacket,
  output logic                         in_ready,
  output logic [13:0]                  mem_address,
  output logic [3:0]                   mem_byteenable,
  output logic                         mem_chipselect,
  output logic                         mem_write,
  output logic [31:0]                  mem_writedata,
  output logic                         mem_clken,
  input  logic                         pkt_release,
  output logic                         pkt_pending,
  output logic [$clog2(NUM_SLOTS):0]   pkt_count,
  output logic [13:0]                  head_addr
);

  localparam int OFF_W  = $clog2(SLOT_WORDS) + 1;
  localparam int SLOT_W = $clog2(NUM_SLOTS);
  localparam int CNT_W  = SLOT_W + 1;
  localparam logic [OFF_W-1:0] LP_END  = OFF_W'(SLOT_WORDS);
  localparam logic [CNT_W-1:0] LP_FULL = CNT_W'(NUM_SLOTS);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DROP, S_COMMIT} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [SLOT_W-1:0]   r_wr_slot;
  logic [SLOT_W-1:0]   r_rd_slot;
  logic [OFF_W-1:0]    r_offset;
  logic [OFF_W-1:0]    w_offset_nxt;
  logic [15:0]         r_stored;
  logic [15:0]         w_stored_nxt;
  logic                r_ovf;
  logic                w_ovf_nxt;
  logic [CNT_W-1:0]    r_count;
  logic                r_mem_write;
  logic [13:0]         r_mem_addr;
  logic [31:0]         r_mem_data;

  logic                w_full;
  logic                w_ready;
  logic                w_accept;
  logic                w_wr_en;
  logic [OFF_W-1:0]    w_wr_off;
  logic [31:0]         w_wr_data;
  logic                w_commit;
  logic                w_rel;
  logic [13:0]         w_wr_addr;

  assign w_full   = (r_count == LP_FULL);
  assign w_accept = in_valid & in_ready;
  assign w_rel    = pkt_release & (r_count != '0);
  // Slot base plus offset; 14-bit arithmetic gives the required truncation for free.
  assign w_wr_addr = 14'(BASE_ADDR) + 14'(r_wr_slot) * 14'(SLOT_WORDS) + 14'(w_wr_off);

  assign in_ready       = reset_n & w_ready;
  assign mem_address    = r_mem_addr;
  assign mem_writedata  = r_mem_data;
  assign mem_write      = r_mem_write;
  assign mem_chipselect = r_mem_write;
  assign mem_byteenable = 4'hF;
  assign mem_clken      = 1'b1;
  assign pkt_count      = r_count;
  assign pkt_pending    = (r_count != '0);
  assign head_addr      = 14'(BASE_ADDR) + 14'(r_rd_slot) * 14'(SLOT_WORDS);

  // Next-state, sink ready and write-request decode.
  always_comb begin
    w_state_nxt  = r_state;
    w_offset_nxt = r_offset;
    w_stored_nxt = r_stored;
    w_ovf_nxt    = r_ovf;
    w_ready      = 1'b0;
    w_wr_en      = 1'b0;
    w_wr_off     = r_offset;
    w_wr_data    = in_data;
    w_commit     = 1'b0;
    case (r_state)
      S_IDLE:   w_ready = !w_full;
      S_WRITE,
      S_DROP:   w_ready = 1'b1;
      default:  w_ready = 1'b0;
    endcase
    if (r_state == S_COMMIT) begin
      w_wr_en     = 1'b1;
      w_wr_off    = '0;
      w_wr_data   = {r_ovf, 15'b0, r_stored};
      w_commit    = 1'b1;
      w_state_nxt = S_IDLE;
    end else if (w_accept && in_startofpacket) begin
      // Any sop (fresh or mid-packet) restarts the slot at payload word 1.
      w_wr_en      = 1'b1;
      w_wr_off     = OFF_W'(1);
      w_offset_nxt = OFF_W'(2);
      w_stored_nxt = 16'd1;
      w_ovf_nxt    = 1'b0;
      if (in_endofpacket) begin
        w_state_nxt = S_COMMIT;
      end else if (OFF_W'(2) == LP_END) begin
        w_ovf_nxt   = 1'b1;
        w_state_nxt = S_DROP;
      end else begin
        w_state_nxt = S_WRITE;
      end
    end else if (w_accept && r_state == S_WRITE) begin
      w_wr_en      = 1'b1;
      w_offset_nxt = r_offset + OFF_W'(1);
      w_stored_nxt = r_stored + 16'd1;
      if (in_endofpacket) begin
        w_state_nxt = S_COMMIT;
      end else if (w_offset_nxt == LP_END) begin
        w_ovf_nxt   = 1'b1;
        w_state_nxt = S_DROP;
      end
    end else if (w_accept && r_state == S_DROP && in_endofpacket) begin
      w_state_nxt = S_COMMIT;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Per-packet write cursor, word count and overflow flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_offset <= '0;
      r_stored <= '0;
      r_ovf    <= 1'b0;
    end else begin
      r_offset <= w_offset_nxt;
      r_stored <= w_stored_nxt;
      r_ovf    <= w_ovf_nxt;
    end
  end

  // Registered memory write port: one-cycle strobe per request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mem_write <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_data  <= '0;
    end else begin
      r_mem_write <= w_wr_en;
      if (w_wr_en) begin
        r_mem_addr <= w_wr_addr;
        r_mem_data <= w_wr_data;
      end
    end
  end

  // Ring pointers and occupancy; commit and release in one cycle cancel in the count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_slot <= '0;
      r_rd_slot <= '0;
      r_count   <= '0;
    end else begin
      if (w_commit) r_wr_slot <= r_wr_slot + SLOT_W'(1);
      if (w_rel)    r_rd_slot <= r_rd_slot + SLOT_W'(1);
      case ({w_commit, w_rel})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_dircc_node_mem_loader.sv
// Bench for dircc_node_mem_loader: directed packets, expected memory writes queued at issue time.
// A negedge monitor pops and checks every mem_write; status outputs are checked inline.
// Every wait on the DUT is bounded; a timeout counts as a failure.
module tb_dircc_node_mem_loader;

  logic        clk;
  logic        reset_n;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_startofpacket;
  logic        in_endofpacket;
  logic        in_ready;
  logic [13:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect;
  logic        mem_write;
  logic [31:0] mem_writedata;
  logic        mem_clken;
  logic        pkt_release;
  logic        pkt_pending;
  logic [3:0]  pkt_count;
  logic [13:0] head_addr;

  int n_checks = 0;
  int n_fail   = 0;
  logic [13:0] exp_addr[$];
  logic [31:0] exp_data[$];

  dircc_node_mem_loader #(.BASE_ADDR(8192), .SLOT_WORDS(16), .NUM_SLOTS(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_data(in_data), .in_valid(in_valid),
    .in_startofpacket(in_startofpacket), .in_endofpacket(in_endofpacket),
    .in_ready(in_ready),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_clken(mem_clken),
    .pkt_release(pkt_release), .pkt_pending(pkt_pending),
    .pkt_count(pkt_count), .head_addr(head_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (mem_write === 1'b1) begin
      if (exp_addr.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: addr %0d data 0x%08h, expected no write", mem_address, mem_writedata);
      end else begin
        logic [13:0] a;
        logic [31:0] d;
        a = exp_addr.pop_front();
        d = exp_data.pop_front();
        chk("wr_addr", 32'(mem_address), 32'(a));
        chk("wr_data", mem_writedata, d);
        chk("wr_be_cs", {27'b0, mem_chipselect, mem_byteenable}, 32'h1F);
      end
    end
  end

  task automatic expect_wr(input int addr, input logic [31:0] data);
    exp_addr.push_back(14'(addr));
    exp_data.push_back(data);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One beat; waits (bounded) for in_ready, returns at posedge+1 with in_valid low.
  task automatic beat(input logic [31:0] d, input logic sop, input logic eop, output int stalls);
    stalls = 0;
    @(negedge clk);
    in_data = d; in_startofpacket = sop; in_endofpacket = eop; in_valid = 1'b1;
    while (!in_ready && stalls < 200) begin
      @(negedge clk);
      stalls++;
    end
    if (stalls >= 200) chk("beat_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_startofpacket = 1'b0; in_endofpacket = 1'b0;
  endtask

  // Whole packet of n words into ring slot `slot`; returns stalls seen after the first beat.
  task automatic send_pkt(input int n, input logic [31:0] base, input int slot, output int late_stalls);
    int s;
    int stored;
    late_stalls = 0;
    stored = (n > 15) ? 15 : n;
    for (int i = 0; i < n; i++) begin
      if (i < 15) expect_wr(8192 + slot * 16 + 1 + i, base + 32'(i));
      if (i == n - 1) expect_wr(8192 + slot * 16, {(n > 15), 15'b0, 16'(stored)});
      beat(base + 32'(i), (i == 0), (i == n - 1), s);
      if (i > 0) late_stalls += s;
    end
  endtask

  task automatic release_pulse();
    pkt_release = 1'b1;
    @(posedge clk);
    #1;
    pkt_release = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_mem_write", 32'(mem_write), 32'd0);
    cyc(2);
    chk("rst_mem_addr", 32'(mem_address), 32'd0);
    chk("rst_mem_data", mem_writedata, 32'd0);
    chk("rst_count", 32'(pkt_count), 32'd0);
    chk("rst_pending", 32'(pkt_pending), 32'd0);
    chk("rst_head", 32'(head_addr), 32'd8192);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("rst_release_in_ready", 32'(in_ready), 32'd1);
    cyc(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    reset_n = 1'b0;
    in_data = '0; in_valid = 1'b0; in_startofpacket = 1'b0; in_endofpacket = 1'b0;
    pkt_release = 1'b0;
    cyc(2);
    do_reset();

    // Single 3-word packet into slot 0.
    send_pkt(3, 32'hA000_0000, 0, st);
    cyc(1);
    chk("p1_count", 32'(pkt_count), 32'd1);
    chk("p1_pending", 32'(pkt_pending), 32'd1);
    chk("p1_head", 32'(head_addr), 32'd8192);
    release_pulse();
    chk("p1_rel_count", 32'(pkt_count), 32'd0);
    chk("p1_rel_head", 32'(head_addr), 32'd8208);

    // 1-beat packet: COMMIT bubble is exactly one cycle.
    send_pkt(1, 32'hDEAD_BEEF, 1, st);
    chk("p2_commit_in_ready", 32'(in_ready), 32'd0);
    cyc(1);
    chk("p2_idle_in_ready", 32'(in_ready), 32'd1);
    chk("p2_count", 32'(pkt_count), 32'd1);
    release_pulse();

    // 20-word packet: 15 payload writes, 5 dropped beats without stalls, overflow header.
    send_pkt(20, 32'hC000_0000, 2, st);
    chk("p3_drop_stalls", 32'(st), 32'd0);
    cyc(1);
    chk("p3_count", 32'(pkt_count), 32'd1);
    release_pulse();
    chk("p3_head", 32'(head_addr), 32'd8240);

    // Release with an empty ring changes nothing.
    release_pulse();
    chk("empty_rel_count", 32'(pkt_count), 32'd0);
    chk("empty_rel_head", 32'(head_addr), 32'd8240);

    // Ring full and wrap from a clean reset.
    do_reset();
    for (int p = 0; p < 8; p++) send_pkt(2, 32'h1000_0000 + 32'(p << 8), p, st);
    cyc(1);
    chk("full_count", 32'(pkt_count), 32'd8);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    fork
      send_pkt(2, 32'h9000_0000, 0, st);
      begin
        cyc(5);
        chk("full_still_blocked", 32'(in_ready), 32'd0);
        release_pulse();
      end
    join
    chk("wrap_head", 32'(head_addr), 32'd8208);
    cyc(1);
    chk("wrap_count", 32'(pkt_count), 32'd8);

    // Release in the COMMIT cycle keeps the count steady.
    release_pulse();
    chk("pre_sim_count", 32'(pkt_count), 32'd7);
    send_pkt(2, 32'h5000_0000, 1, st);
    release_pulse();
    chk("sim_count", 32'(pkt_count), 32'd7);
    chk("sim_head", 32'(head_addr), 32'd8240);

    // sop mid-packet restarts at offset 1 of the same slot (slot 2).
    expect_wr(8225, 32'hB000_0000); beat(32'hB000_0000, 1'b1, 1'b0, st);
    expect_wr(8226, 32'hB000_0001); beat(32'hB000_0001, 1'b0, 1'b0, st);
    expect_wr(8225, 32'hC0C0_0000); beat(32'hC0C0_0000, 1'b1, 1'b0, st);
    expect_wr(8226, 32'hC0C0_0001);
    expect_wr(8224, 32'h0000_0002);
    beat(32'hC0C0_0001, 1'b0, 1'b1, st);
    cyc(1);
    chk("restart_count", 32'(pkt_count), 32'd8);

    // Reset mid-WRITE: strobe drops at once, partial packet never gets a header.
    release_pulse();
    expect_wr(8241, 32'hD000_0000);
    beat(32'hD000_0000, 1'b1, 1'b0, st);
    beat(32'hD000_0001, 1'b0, 1'b0, st);
    chk("midwr_strobe", 32'(mem_write), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("midwr_async_drop", 32'(mem_write), 32'd0);
    chk("midwr_addr_clr", 32'(mem_address), 32'd0);
    cyc(2);
    chk("midwr_count", 32'(pkt_count), 32'd0);
    chk("midwr_in_ready", 32'(in_ready), 32'd0);
    chk("midwr_head", 32'(head_addr), 32'd8192);
    @(negedge clk);
    reset_n = 1'b1;
    cyc(1);
    send_pkt(3, 32'hE000_0000, 0, st);
    cyc(1);
    chk("post_rst_count", 32'(pkt_count), 32'd1);
    chk("post_rst_head", 32'(head_addr), 32'd8192);

    cyc(5);
    chk("queue_drained", 32'(exp_addr.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
